// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
// Holds the receive FSM encoding, the CPU-visible addresses and the status word layout.
// Imported by the receiver top, its FIFO and the CPU-side decode.
package uart_rx_pkg;

    // Receive FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_t;

    localparam int UART_DATA_W = 8;

    // CPU load addresses. The memory-access stage pops the FIFO when it loads
    // from UART_RX_ADDR (uart_rd = load && alu_result == UART_RX_ADDR).
    localparam logic [31:0] UART_RX_ADDR   = 32'h0000_4000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h0000_4004;

    // Status word as seen at UART_STAT_ADDR, bits [3:0].
    typedef struct packed {
        logic busy;
        logic ovf;
        logic ferr;
        logic valid;
    } uart_stat_t;

    function automatic logic [31:0] uart_stat_word(input uart_stat_t s);
        return {28'd0, s};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side bus of the UART receiver: pop/clear strobes in, head byte and flags out.
// Latency: none of its own (plain wires).
// Backpressure: none; the receiver side reports overrun instead of stalling the line.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                   uart_rd;     // pop strobe, one pop per high cycle
    logic                   uart_clr;    // clears both sticky flags
    logic [UART_DATA_W-1:0] uart_dat;    // FIFO head (show-ahead), 0 when empty
    logic                   uart_valid;  // FIFO not empty
    logic                   uart_ferr;   // sticky framing error
    logic                   uart_ovf;    // sticky overrun
    logic                   uart_busy;   // receive FSM not idle

    // CPU / memory-access stage side.
    modport master (
        output uart_rd,
        output uart_clr,
        input  uart_dat,
        input  uart_valid,
        input  uart_ferr,
        input  uart_ovf,
        input  uart_busy
    );

    // Receiver side.
    modport slave (
        input  uart_rd,
        input  uart_clr,
        output uart_dat,
        output uart_valid,
        output uart_ferr,
        output uart_ovf,
        output uart_busy
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small show-ahead FIFO for received bytes.
// Latency: a pushed word is on dout the cycle after the push edge; dout is 0 while empty.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk, rst_n (async active-low), push, pop, din -> dout, empty, full.
module uart_rx_fifo #(
    parameter int DEPTH = 4,       // power of 2, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO still fits.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: nothing is visible until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the RX pin, assembles bytes LSB-first into a FIFO, reports sticky framing/overrun errors.
// Latency: a byte is on uart_dat with uart_valid=1 the cycle after its stop-bit sample.
// Backpressure: none toward the line; a byte arriving at a full FIFO (no same-cycle pop) is dropped and sets uart_ovf.
// Ports: sys_clk_i, sys_rstn_i (async active-low), uart_rx_i (async pin, idles high),
//        bus (slave): uart_rd, uart_clr in; uart_dat, uart_valid, uart_ferr, uart_ovf, uart_busy out.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BAUD       = 115200,      // CLK_HZ/BAUD must be >= 4
    parameter int FIFO_DEPTH = 4            // power of 2, >= 2
) (
    input  logic     sys_clk_i,
    input  logic     sys_rstn_i,
    input  logic     uart_rx_i,
    uart_rx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Synchronizer and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_m;     // first synchronizer flop (metastability catcher)
    logic rx_s;     // synchronized line
    logic rx_d;     // rx_s delayed by one cycle
    logic fall;

    // Reset to 1 so a line that idles high produces no edge after release.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= uart_rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Edge rather than level: a line stuck low cannot retrigger reception.
    assign fall = rx_d & ~rx_s;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t        state;
    rx_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tick;
    logic             push;
    logic             ferr_set;
    logic             busy;

    assign tick = (cnt == '0);

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) state <= ST_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fall) state_nxt = ST_START;
            // Line back high at mid start bit means it was a glitch.
            ST_START: if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bit_idx == 3'd7) state_nxt = ST_STOP;
            ST_STOP:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        push     = 1'b0;
        ferr_set = 1'b0;
        if (state == ST_STOP && tick) begin
            push     = rx_s;
            ferr_set = ~rx_s;
        end
    end

    // Baud counter, bit index and shift register. The half-bit first load
    // puts every later sample in the middle of its bit.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fall) cnt <= CNT_HALF;
                end
                ST_START: begin
                    if (tick) begin
                        cnt     <= CNT_FULL;
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= {rx_s, shift[7:1]};
                        cnt     <= CNT_FULL;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!tick) cnt <= cnt - 1'b1;
                end
                default: cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_full;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst_n (sys_rstn_i),
        .push  (push),
        .pop   (bus.uart_rd),
        .din   (shift),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // ------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------
    logic ovf_set;
    logic ferr_q;
    logic ovf_q;

    // A pop in the same cycle makes room, so that case is not an overrun.
    assign ovf_set = push & fifo_full & ~bus.uart_rd;

    // Set has priority over clear so an error in the clearing cycle is kept.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_set | (ferr_q & ~bus.uart_clr);
            ovf_q  <= ovf_set  | (ovf_q  & ~bus.uart_clr);
        end
    end

    assign bus.uart_dat   = fifo_dout;
    assign bus.uart_valid = ~fifo_empty;
    assign bus.uart_ferr  = ferr_q;
    assign bus.uart_ovf   = ovf_q;
    assign bus.uart_busy  = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit (1 MHz / 100 kBd).
// Frames are driven starting #1 after a rising edge; outputs are sampled #1 after rising edges.
// Expected values are hand-computed constants.
module tb_uart_rx;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rx_line = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rstn_i (rst_n),
        .uart_rx_i  (rx_line),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_lat = 0;
    logic busy_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame, 10 clocks per bit; returns with the line high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_line = 1'b0;
        step(10);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            step(10);
        end
        rx_line = stop_bit;
        step(10);
        rx_line = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, {23'd0, bus.uart_valid, bus.uart_dat}, {23'd0, 1'b1, exp});
        bus.uart_rd = 1'b1;
        step(1);
        bus.uart_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.uart_clr = 1'b1;
        step(1);
        bus.uart_clr = 1'b0;
    endtask

    initial begin
        bus.uart_rd  = 1'b0;
        bus.uart_clr = 1'b0;

        // Reset state
        step(3);
        check("rst_dat",   bus.uart_dat,   8'h00);
        check("rst_valid", bus.uart_valid, 1'b0);
        check("rst_ferr",  bus.uart_ferr,  1'b0);
        check("rst_ovf",   bus.uart_ovf,   1'b0);
        check("rst_busy",  bus.uart_busy,  1'b0);
        rst_n = 1'b1;
        step(5);

        // 8'hA5: edge seen at clk 3, start sample 8, data 18..88, stop 98 -> valid after edge 98
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int k = 1; k <= 150; k++) begin
                    step(1);
                    if (bus.uart_valid && n_lat == 0) n_lat = k;
                end
            end
        join
        check("a5_latency", n_lat, 98);
        check("a5_ferr", bus.uart_ferr, 1'b0);
        check("a5_ovf",  bus.uart_ovf,  1'b0);
        pop_check("a5_dat", 8'hA5);
        check("a5_empty", bus.uart_valid, 1'b0);

        // Back-to-back frames, no reads in between
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        step(5);
        pop_check("b2b_00", 8'h00);
        pop_check("b2b_ff", 8'hFF);
        pop_check("b2b_3c", 8'h3C);
        check("b2b_empty", bus.uart_valid, 1'b0);

        // Overrun: 5 bytes into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        step(5);
        check("ovf_set", bus.uart_ovf, 1'b1);
        pop_check("ovf_01", 8'h01);
        pop_check("ovf_02", 8'h02);
        pop_check("ovf_03", 8'h03);
        pop_check("ovf_04", 8'h04);
        check("ovf_05_lost", bus.uart_valid, 1'b0);
        pulse_clr();
        check("ovf_clr", bus.uart_ovf, 1'b0);

        // Framing error, then a good byte
        send_frame(8'h55, 1'b0);
        step(20);
        check("ferr_set",   bus.uart_ferr,  1'b1);
        check("ferr_nobyte", bus.uart_valid, 1'b0);
        send_frame(8'h12, 1'b1);
        step(5);
        check("ferr_sticky", bus.uart_ferr, 1'b1);
        pop_check("ferr_12", 8'h12);
        pulse_clr();
        check("ferr_clr", bus.uart_ferr, 1'b0);

        // 3-clock low glitch on an idle line
        busy_seen = 1'b0;
        rx_line   = 1'b0;
        fork
            begin
                step(3);
                rx_line = 1'b1;
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    step(1);
                    if (bus.uart_busy) busy_seen = 1'b1;
                end
            end
        join
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_idle",  bus.uart_busy,  1'b0);
        check("glitch_valid", bus.uart_valid, 1'b0);
        check("glitch_flags", {bus.uart_ferr, bus.uart_ovf}, 2'b00);

        // Full FIFO: pop in the same cycle as the stop-bit push (edge 98)
        send_frame(8'h10, 1'b1);
        send_frame(8'h20, 1'b1);
        send_frame(8'h30, 1'b1);
        send_frame(8'h40, 1'b1);
        step(5);
        fork
            send_frame(8'h50, 1'b1);
            begin
                step(97);
                bus.uart_rd = 1'b1;
                step(1);
                bus.uart_rd = 1'b0;
            end
        join
        step(5);
        check("pp_no_ovf", bus.uart_ovf, 1'b0);
        pop_check("pp_20", 8'h20);
        pop_check("pp_30", 8'h30);
        pop_check("pp_40", 8'h40);
        pop_check("pp_50", 8'h50);
        check("pp_empty", bus.uart_valid, 1'b0);

        // Reset in the middle of a frame
        send_frame(8'h77, 1'b1);
        step(5);
        fork
            send_frame(8'h99, 1'b1);
            begin
                step(39);
                check("mid_busy", bus.uart_busy, 1'b1);
                rst_n = 1'b0;
                step(1);
                check("mid_rst_out", {bus.uart_busy, bus.uart_valid, bus.uart_dat}, 10'h000);
            end
        join
        rst_n = 1'b1;
        step(150);
        check("post_rst_valid", bus.uart_valid, 1'b0);
        check("post_rst_busy",  bus.uart_busy,  1'b0);
        check("post_rst_flags", {bus.uart_ferr, bus.uart_ovf}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
